interval_scheduler: RTL and testbench

INTERVAL_SCHEDULER -- requirements
Module: interval_scheduler

---
 rtl/interval_sched_pkg.sv | 13 +
 rtl/interval_scheduler_counter.sv | 21 ++
 rtl/interval_scheduler.sv | 120 ++++++++++++
 tb/tb_interval_scheduler.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/interval_sched_pkg.sv
// Shared definitions for the interval scheduler: FSM encoding and default sizing.
package interval_sched_pkg;

   localparam int DEF_NUM_REQ   = 4;
   localparam int DEF_CNT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/interval_scheduler_counter.sv
// Up-counter with synchronous reset and enable; wraps to zero after MAX_VALUE.
module interval_scheduler_counter #(
   parameter int              SIZE      = 8,
   parameter logic [SIZE-1:0] MAX_VALUE = {SIZE{1'b1}}
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            enable,
   output logic [SIZE-1:0] count
);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (enable) begin
         count <= (count == MAX_VALUE) ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/interval_scheduler.sv
// Round-robin owner of one shared interval timer: IDLE selects, RUN counts to L, DONE pulses.
module interval_scheduler
   import interval_sched_pkg::*;
#(
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ*CNT_WIDTH-1:0]   len,
   output logic [NUM_REQ-1:0]             grant,
   output logic [NUM_REQ-1:0]             done,
   output logic                           busy,
   output logic [CNT_WIDTH-1:0]           count
);

   localparam int               IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

   state_t                 state, state_n;
   logic [IDX_W-1:0]       idx, idx_n, ptr, ptr_n, pick_idx, idx_after;
   logic [IDX_W:0]         cand;
   logic                   pick_found;
   logic [CNT_WIDTH-1:0]   len_q, len_n, pick_len, cnt;
   logic [NUM_REQ-1:0]     owner_mask;
   logic                   owner_req;

   // First set request at or above ptr, wrapping to the lowest index.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, ptr} + (IDX_W + 1)'(k);
         if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
         if (!pick_found && req[cand[IDX_W-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = cand[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      pick_len = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_idx == IDX_W'(i)) pick_len = len[i*CNT_WIDTH +: CNT_WIDTH];
      end
   end

   assign owner_mask = NUM_REQ'(1) << idx;
   assign owner_req  = |(req & owner_mask);
   assign idx_after  = (idx == LAST_IDX) ? '0 : idx + 1'b1;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_n = state;
      idx_n   = idx;
      len_n   = len_q;
      ptr_n   = ptr;
      grant   = '0;
      done    = '0;
      busy    = 1'b0;
      count   = '0;
      case (state)
         IDLE: begin
            if (pick_found) begin
               state_n = RUN;
               idx_n   = pick_idx;
               len_n   = pick_len;
            end
         end
         RUN: begin
            grant = owner_mask;
            busy  = 1'b1;
            count = cnt;
            // A dropped request outranks reaching the terminal count.
            if (!owner_req) begin
               state_n = IDLE;
               ptr_n   = idx_after;
            end else if (cnt == len_q) begin
               state_n = DONE;
            end
         end
         DONE: begin
            done    = owner_mask;
            busy    = 1'b1;
            state_n = IDLE;
            ptr_n   = idx_after;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         ptr   <= '0;
         idx   <= '0;
         len_q <= '0;
      end else begin
         state <= state_n;
         ptr   <= ptr_n;
         idx   <= idx_n;
         len_q <= len_n;
      end
   end

   // Held at zero outside RUN, so each interval starts from 0 and cannot wrap before DONE.
   interval_scheduler_counter #(
      .SIZE (CNT_WIDTH)
   ) u_timer (
      .clk    (clk),
      .reset  (reset || (state != RUN)),
      .enable (state == RUN),
      .count  (cnt)
   );

endmodule

// File: tb/tb_interval_scheduler.sv
// Directed and random stimulus compared each cycle with an interval-level reference model.
module tb_interval_scheduler;

   localparam int N = 4;
   localparam int W = 4;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] len = '0;
   logic [N-1:0]   grant;
   logic [N-1:0]   done;
   logic           busy;
   logic [W-1:0]   count;

   int checks = 0;
   int errors = 0;
   int run_cycles = 0;
   int done_pulses = 0;

   // Reference model: owner (-1 none), elapsed count, latched length, pending done, pointer.
   bit m_valid = 1'b0;
   int m_owner = -1;
   int m_count = 0;
   int m_len   = 0;
   int m_done  = -1;
   int m_ptr   = 0;

   interval_scheduler #(
      .NUM_REQ   (N),
      .CNT_WIDTH (W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .len   (len),
      .grant (grant),
      .done  (done),
      .busy  (busy),
      .count (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_step(input logic [N-1:0] r, input logic [N*W-1:0] l, input logic rs);
      logic [N*W-1:0] sh;
      if (rs) begin
         m_owner = -1;
         m_done  = -1;
         m_ptr   = 0;
         m_valid = 1'b1;
         return;
      end
      if (!m_valid) return;
      if (m_done >= 0) begin
         m_done = -1;
      end else if (m_owner >= 0) begin
         if (!r[m_owner[1:0]]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
         end else if (m_count == m_len) begin
            m_done  = m_owner;
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
         end else begin
            m_count++;
         end
      end else if (r != '0) begin
         for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (r[j[1:0]]) begin
               m_owner = j;
               break;
            end
         end
         m_count = 0;
         sh      = l >> (W * m_owner);
         m_len   = int'(sh[W-1:0]);
      end
   endfunction

   task automatic compare();
      logic [31:0] eg, ed, ec, eb;
      if (m_valid) begin
         eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
         ec = (m_owner >= 0) ? 32'(m_count) : 32'd0;
         ed = (m_done >= 0) ? (32'd1 << m_done) : 32'd0;
         eb = (m_owner >= 0 || m_done >= 0) ? 32'd1 : 32'd0;
         check("grant", 32'(grant), eg);
         check("count", 32'(count), ec);
         check("done",  32'(done),  ed);
         check("busy",  32'(busy),  eb);
      end
      if (grant != '0) run_cycles++;
      if (done != '0) done_pulses++;
   endtask

   // Compare what the previous edge produced, then present inputs for the next edge.
   task automatic step(input logic [N-1:0] r, input logic [N*W-1:0] l, input logic rs);
      @(negedge clk);
      compare();
      req   = r;
      len   = l;
      reset = rs;
      model_step(r, l, rs);
   endtask

   task automatic hold(input logic [N-1:0] r, input logic [N*W-1:0] l, input int n);
      repeat (n) step(r, l, 1'b0);
   endtask

   task automatic clear_tallies();
      run_cycles  = 0;
      done_pulses = 0;
   endtask

   initial begin
      logic [N-1:0]   rr;
      logic [N*W-1:0] rl;
      logic           rs;

      step('0, '0, 1'b1);
      step('0, '0, 1'b1);

      // Single request, L=3.
      clear_tallies();
      hold(4'b0001, 16'h0003, 5);
      hold(4'b0000, 16'h0003, 3);
      check("single_run_cycles", 32'(run_cycles), 32'd4);
      check("single_done_pulses", 32'(done_pulses), 32'd1);

      // Fairness with all lengths zero.
      step('0, '0, 1'b1);
      clear_tallies();
      hold(4'b1111, 16'h0000, 15);
      hold(4'b0000, 16'h0000, 3);
      check("fair_run_cycles", 32'(run_cycles), 32'd5);
      check("fair_done_pulses", 32'(done_pulses), 32'd5);

      // Abort at count 4, then requester 0 wins against requester 1.
      step('0, '0, 1'b1);
      clear_tallies();
      hold(4'b0010, 16'h00A0, 5);
      step(4'b0000, 16'h00A0, 1'b0);
      step(4'b0011, 16'h0000, 1'b0);
      check("abort_done_pulses", 32'(done_pulses), 32'd0);
      check("abort_grant_cleared", 32'(grant), 32'd0);
      hold(4'b0011, 16'h0000, 3);
      hold(4'b0000, 16'h0000, 3);

      // Full-range length: 16 RUN cycles, no wrap.
      step('0, '0, 1'b1);
      clear_tallies();
      hold(4'b0100, 16'h0F00, 18);
      hold(4'b0000, 16'h0000, 3);
      check("boundary_run_cycles", 32'(run_cycles), 32'd16);
      check("boundary_done_pulses", 32'(done_pulses), 32'd1);

      // Reset in the middle of an interval.
      step('0, '0, 1'b1);
      clear_tallies();
      hold(4'b0001, 16'h0005, 3);
      step(4'b0001, 16'h0005, 1'b1);
      step(4'b1001, 16'h0000, 1'b0);
      check("midreset_grant", 32'(grant), 32'd0);
      check("midreset_busy", 32'(busy), 32'd0);
      check("midreset_done_pulses", 32'(done_pulses), 32'd0);
      hold(4'b1001, 16'h0000, 3);
      hold(4'b0000, 16'h0000, 4);

      // Length change during RUN is ignored.
      step('0, '0, 1'b1);
      clear_tallies();
      hold(4'b0001, 16'h0006, 3);
      hold(4'b0001, 16'h0001, 6);
      hold(4'b0000, 16'h0000, 3);
      check("lenchange_run_cycles", 32'(run_cycles), 32'd7);

      // Random traffic.
      step('0, '0, 1'b1);
      rr = '0;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (rr[i]) begin
               if ($urandom_range(0, 15) == 0) rr[i] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
               rr[i] = 1'b1;
            end
         end
         for (int i = 0; i < N; i++) begin
            rl[i*W +: W] = ($urandom_range(0, 19) == 0) ? 4'hF : W'($urandom_range(0, 5));
         end
         rs = ($urandom_range(0, 199) == 0);
         step(rr, rl, rs);
      end
      @(negedge clk);
      compare();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
